// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-bus signals around mem_arbiter.
// The arbiter uses the master modport; slave is the view of the surrounding datapath and memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_addr, ls_we, ls_wdata, ls_wstrb,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_addr, ls_we, ls_wdata, ls_wstrb,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store: LS priority with a starvation
// guard for IF, one outstanding transaction, and a per-transaction timeout.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_ls_q, owner_ls_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          if_err_q, if_err_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic          ls_err_q, ls_err_d;
  logic          if_gnt, ls_gnt, ls_win;
  logic          done;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    ls_win      = 1'b0;
    done        = 1'b0;
    rsp_data    = '0;
    rsp_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          ls_win = bus.ls_req && !(bus.if_req && (starve_q == SW'(STARVE_LIMIT)));
          if (ls_win) begin
            ls_gnt     = 1'b1;
            owner_ls_d = 1'b1;
            addr_d     = bus.ls_addr;
            we_d       = bus.ls_we;
            wdata_d    = bus.ls_wdata;
            wstrb_d    = bus.ls_wstrb;
            if (!bus.if_req)
              starve_d = '0;
            else if (starve_q != SW'(STARVE_LIMIT))
              starve_d = starve_q + 1'b1;
          end else begin
            if_gnt     = 1'b1;
            owner_ls_d = 1'b0;
            addr_d     = bus.if_addr;
            we_d       = 1'b0;
            wdata_d    = '0;
            wstrb_d    = '0;
            starve_d   = '0;
          end
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack on the final timeout cycle still completes normally.
        if (bus.mem_ack) begin
          done     = 1'b1;
          rsp_data = we_q ? '0 : bus.mem_rdata;
        end else if ((TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1))) begin
          done    = 1'b1;
          rsp_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (done) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if_rvalid_d = done && !owner_ls_q;
    if_rdata_d  = (done && !owner_ls_q) ? rsp_data : '0;
    if_err_d    = done && !owner_ls_q && rsp_err;
    ls_rvalid_d = done && owner_ls_q;
    ls_rdata_d  = (done && owner_ls_q) ? rsp_data : '0;
    ls_err_d    = done && owner_ls_q && rsp_err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_ls_q  <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_err    = ls_err_q;
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-timing model of the arbiter.
module tb_mem_arbiter;
  localparam int SL  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        x_if_gnt;
    logic        x_ls_gnt;
    logic        x_mem_req;
    logic [31:0] x_mem_addr;
    logic        x_mem_we;
    logic [31:0] x_mem_wdata;
    logic [3:0]  x_mem_wstrb;
    logic        x_if_rv;
    logic [31:0] x_if_rd;
    logic        x_if_err;
    logic        x_ls_rv;
    logic [31:0] x_ls_rd;
    logic        x_ls_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.if_req = 0; bus.if_addr = '0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_wstrb = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.if_req = v.if_req; bus.if_addr = v.if_addr;
    bus.ls_req = v.ls_req; bus.ls_we = v.ls_we; bus.ls_addr = v.ls_addr;
    bus.ls_wdata = v.ls_wdata; bus.ls_wstrb = v.ls_wstrb;
    bus.mem_ack = v.mem_ack; bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".if_gnt"},    32'(bus.if_gnt),    32'(v.x_if_gnt));
    chk({tag, ".ls_gnt"},    32'(bus.ls_gnt),    32'(v.x_ls_gnt));
    chk({tag, ".mem_req"},   32'(bus.mem_req),   32'(v.x_mem_req));
    chk({tag, ".mem_addr"},  bus.mem_addr,       v.x_mem_addr);
    chk({tag, ".mem_we"},    32'(bus.mem_we),    32'(v.x_mem_we));
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      v.x_mem_wdata);
    chk({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.x_mem_wstrb));
    chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(v.x_if_rv));
    chk({tag, ".if_rdata"},  bus.if_rdata,       v.x_if_rd);
    chk({tag, ".if_err"},    32'(bus.if_err),    32'(v.x_if_err));
    chk({tag, ".ls_rvalid"}, 32'(bus.ls_rvalid), 32'(v.x_ls_rv));
    chk({tag, ".ls_rdata"},  bus.ls_rdata,       v.x_ls_rd);
    chk({tag, ".ls_err"},    32'(bus.ls_err),    32'(v.x_ls_err));
  endtask

  // One complete non-timeout transaction; ack comes lat cycles after mem_req rises.
  task automatic txn(input string tag, input bit is_ls, input logic [31:0] addr,
                     input int lat, input logic [31:0] data);
    if (is_ls) begin
      bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = addr;
    end else begin
      bus.if_req = 1; bus.if_addr = addr;
    end
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(is_ls ? bus.ls_gnt : bus.if_gnt), 32'd1);
    cyc_start();
    set_idle();
    for (int c = 1; c <= lat + 2; c++) begin
      bus.mem_ack   = (c == lat + 1);
      bus.mem_rdata = data;
      @(negedge clk);
      if (c <= lat + 1) chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
      if (c == lat + 2) begin
        chk({tag, ".rvalid"}, 32'(is_ls ? bus.ls_rvalid : bus.if_rvalid), 32'd1);
        chk({tag, ".rdata"},  is_ls ? bus.ls_rdata : bus.if_rdata, data);
        chk({tag, ".err"},    32'(is_ls ? bus.ls_err : bus.if_err), 32'd0);
      end
      cyc_start();
    end
    set_idle();
  endtask

  initial begin
    vec_t z;
    int   k, last_g, nreq;
    bit   seen;

    tbl[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
               1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
               0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 32'h40, 32'h12345678, 4'hF, 0, 0,
               0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555,
               0, 0, 1, 32'h40, 1, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 32'h40, 1, 32'h12345678, 4'hF, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 32'h80, 0, 0, 1, 32'h11111111,
               0, 1, 0, 32'h40, 1, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D,
               0, 0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 32'h80, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0};

    // Reset state
    set_idle();
    z = '{default: 0};
    @(negedge clk);
    chk_vec("reset", z);
    cyc_start();
    rst = 0;

    // Directed vectors: fetch with 2-cycle latency, store, load with stray ack in IDLE
    for (int i = 0; i < 10; i++) begin
      apply_vec(tbl[i]);
      @(negedge clk);
      chk_vec($sformatf("vec%0d", i), tbl[i]);
      cyc_start();
    end
    set_idle();

    // Both requesters held: LS x SL, then IF, one grant every 3 cycles
    k = 0; last_g = -1;
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.ls_req = 1; bus.ls_addr = 32'h300;
    for (int c = 0; c < 60 && k < 12; c++) begin
      bus.mem_ack = bus.mem_req;
      @(negedge clk);
      chk("starve.both_gnt", 32'(bus.if_gnt && bus.ls_gnt), 32'd0);
      if (bus.if_gnt || bus.ls_gnt) begin
        chk($sformatf("starve.order%0d", k), 32'(bus.if_gnt), 32'((k % (SL + 1)) == SL));
        if (last_g >= 0) chk("starve.gap", 32'(c - last_g), 32'd3);
        last_g = c;
        k++;
      end
      cyc_start();
    end
    chk("starve.grants", 32'(k), 32'd12);
    set_idle();
    for (int c = 0; c < 3; c++) begin
      bus.mem_ack = bus.mem_req;
      @(negedge clk);
      cyc_start();
    end
    set_idle();

    // Timeout on a load, then a normal fetch
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h500;
    @(negedge clk);
    chk("tmo.gnt", 32'(bus.ls_gnt), 32'd1);
    cyc_start();
    set_idle();
    nreq = 0; seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_req) nreq++;
      if (bus.ls_rvalid) begin
        seen = 1;
        chk("tmo.rv_cycle", 32'(c), 32'(TMO + 1));
        chk("tmo.err", 32'(bus.ls_err), 32'd1);
        chk("tmo.rdata", bus.ls_rdata, 32'd0);
        chk("tmo.if_rvalid", 32'(bus.if_rvalid), 32'd0);
      end
      cyc_start();
      if (seen) break;
    end
    chk("tmo.seen", 32'(seen), 32'd1);
    chk("tmo.req_cycles", 32'(nreq), 32'(TMO));
    txn("after_tmo", 0, 32'h504, 1, 32'hCAFE0001);

    // Ack on the last timeout cycle wins
    txn("ack_at_tmo", 1, 32'h600, TMO - 1, 32'h5A5A1234);

    // Reset in REQ: mem_req drops at once, no response, stray acks ignored
    bus.if_req = 1; bus.if_addr = 32'h700;
    @(negedge clk);
    chk("rst.gnt", 32'(bus.if_gnt), 32'd1);
    cyc_start();
    set_idle();
    @(negedge clk);
    chk("rst.req_before", 32'(bus.mem_req), 32'd1);
    cyc_start();
    #2 rst = 1;
    #1;
    chk("rst.req_drop", 32'(bus.mem_req), 32'd0);
    chk("rst.addr_drop", bus.mem_addr, 32'd0);
    cyc_start();
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      bus.mem_ack = (c < 2); bus.mem_rdata = 32'hFFFF0000;
      @(negedge clk);
      chk("rst.no_if_rv", 32'(bus.if_rvalid), 32'd0);
      chk("rst.no_ls_rv", 32'(bus.ls_rvalid), 32'd0);
      chk("rst.no_req", 32'(bus.mem_req), 32'd0);
      cyc_start();
    end
    set_idle();
    txn("after_rst", 0, 32'h704, 0, 32'h13572468);

    // Randomized traffic against a transaction-timing model
    begin
      bit          busy = 0, own_ls = 0, if_pend = 0, ls_pend = 0;
      bit          in_req, rv, g_if, g_ls, t_err = 0;
      int          g_cyc = 0, ack_cyc = -1, resp_cyc = -1, starve = 0, lat;
      logic [31:0] if_a = '0, ls_a = '0, ls_d = '0, ack_data = '0;
      logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
      logic [3:0]  ls_s = '0, t_wstrb = '0;
      logic        ls_w = 0, t_we = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
        if (!if_pend && $urandom_range(0, 2) == 0) begin
          if_pend = 1; if_a = $urandom;
        end
        if (!ls_pend && $urandom_range(0, 2) == 0) begin
          ls_pend = 1; ls_a = $urandom; ls_w = 1'($urandom_range(0, 1));
          ls_d = $urandom; ls_s = 4'($urandom_range(0, 15));
        end
        in_req = busy && cyc > g_cyc && cyc < resp_cyc;
        bus.if_req = if_pend; bus.if_addr = if_a;
        bus.ls_req = ls_pend; bus.ls_addr = ls_a; bus.ls_we = ls_w;
        bus.ls_wdata = ls_d; bus.ls_wstrb = ls_s;
        bus.mem_ack   = in_req ? (cyc == ack_cyc) : ($urandom_range(0, 3) == 0);
        bus.mem_rdata = (in_req && cyc == ack_cyc) ? ack_data : $urandom;
        @(negedge clk);
        g_if = 0; g_ls = 0;
        if (!busy && (if_pend || ls_pend)) begin
          if (ls_pend && !(if_pend && starve == SL)) g_ls = 1;
          else g_if = 1;
        end
        rv = busy && cyc == resp_cyc;
        chk("rnd.if_gnt", 32'(bus.if_gnt), 32'(g_if));
        chk("rnd.ls_gnt", 32'(bus.ls_gnt), 32'(g_ls));
        chk("rnd.mem_req", 32'(bus.mem_req), 32'(in_req));
        if (in_req) begin
          chk("rnd.mem_addr", bus.mem_addr, t_addr);
          chk("rnd.mem_we", 32'(bus.mem_we), 32'(t_we));
          chk("rnd.mem_wdata", bus.mem_wdata, t_wdata);
          chk("rnd.mem_wstrb", 32'(bus.mem_wstrb), 32'(t_wstrb));
        end
        chk("rnd.if_rvalid", 32'(bus.if_rvalid), 32'(rv && !own_ls));
        chk("rnd.if_rdata", bus.if_rdata, (rv && !own_ls) ? t_rdata : 32'd0);
        chk("rnd.if_err", 32'(bus.if_err), 32'(rv && !own_ls && t_err));
        chk("rnd.ls_rvalid", 32'(bus.ls_rvalid), 32'(rv && own_ls));
        chk("rnd.ls_rdata", bus.ls_rdata, (rv && own_ls) ? t_rdata : 32'd0);
        chk("rnd.ls_err", 32'(bus.ls_err), 32'(rv && own_ls && t_err));
        if (rv) busy = 0;
        if (g_if || g_ls) begin
          busy = 1; g_cyc = cyc; own_ls = g_ls;
          if (g_ls) starve = if_pend ? ((starve + 1 > SL) ? SL : starve + 1) : 0;
          else starve = 0;
          if (g_ls) begin
            t_addr = ls_a; t_we = ls_w; t_wdata = ls_d; t_wstrb = ls_s; ls_pend = 0;
          end else begin
            t_addr = if_a; t_we = 0; t_wdata = '0; t_wstrb = '0; if_pend = 0;
          end
          lat = $urandom_range(0, 10);
          if (lat < TMO) begin
            ack_cyc = cyc + 1 + lat; resp_cyc = cyc + 2 + lat; t_err = 0;
            ack_data = $urandom; t_rdata = t_we ? 32'd0 : ack_data;
          end else begin
            ack_cyc = -1; resp_cyc = cyc + 1 + TMO; t_err = 1; t_rdata = '0;
          end
        end
        cyc_start();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
